// File: rtl/branch_predict_unit_if.sv
// Fetch-lookup and decode-resolve signal bundle for branch_predict_unit.
// The master side drives the pipeline inputs; the slave side is the predictor.
interface branch_predict_unit_if #(
    parameter int unsigned DATA_W = 32
);
    // Fetch-stage lookup
    logic [31:0]       f_pc;
    logic              f_pred_taken;

    // Decode-stage resolve inputs
    logic              d_valid;
    logic              d_stall;
    logic [31:0]       d_pc;
    logic [2:0]        d_branch_op;
    logic [DATA_W-1:0] d_rs;
    logic [DATA_W-1:0] d_rt;
    logic              d_pred_taken;
    logic [31:0]       d_target;

    // Decode-stage resolve outputs and statistics
    logic              br_taken;
    logic              mispredict;
    logic [31:0]       redirect_pc;
    logic [31:0]       stat_branches;
    logic [31:0]       stat_misses;

    modport master (
        output f_pc,
        input  f_pred_taken,
        output d_valid, d_stall, d_pc, d_branch_op, d_rs, d_rt, d_pred_taken, d_target,
        input  br_taken, mispredict, redirect_pc, stat_branches, stat_misses
    );

    modport slave (
        input  f_pc,
        output f_pred_taken,
        input  d_valid, d_stall, d_pc, d_branch_op, d_rs, d_rt, d_pred_taken, d_target,
        output br_taken, mispredict, redirect_pc, stat_branches, stat_misses
    );
endinterface

// File: rtl/branch_predict_unit.sv
// Branch prediction and resolution for the pipelined MIPS core.
// F: 2-bit saturating-counter BHT lookup indexed by pc[IDX_W+1:2] (untagged).
// D: resolves the branch from forwarded operands, flags mispredicts with the
//    correct next fetch PC, trains the BHT and keeps saturating statistics.
module branch_predict_unit #(
    parameter int unsigned DATA_W   = 32,
    parameter int unsigned IDX_W    = 6,
    parameter logic [1:0]  INIT_CNT = 2'b01
) (
    input  logic clk,
    input  logic reset,
    branch_predict_unit_if.slave bpu
);
    localparam int unsigned DEPTH = 1 << IDX_W;

    typedef enum logic [2:0] {
        OP_NONE = 3'b000,
        OP_BEQ  = 3'b001,
        OP_BNE  = 3'b010,
        OP_BGTZ = 3'b011,
        OP_BLEZ = 3'b100,
        OP_BLTZ = 3'b101,
        OP_BGEZ = 3'b110,
        OP_RSVD = 3'b111
    } branch_op_e;

    logic [1:0]       bht [DEPTH];
    logic [31:0]      stat_branches_q;
    logic [31:0]      stat_misses_q;

    logic [IDX_W-1:0] f_idx;
    logic [IDX_W-1:0] d_idx;
    branch_op_e       op;
    logic             is_branch;
    logic             cond;
    logic             resolve;
    logic             taken;
    logic             miss;
    logic             rs_neg;
    logic             rs_zero;
    logic [31:0]      fall_through;

    // Only the index bits of the fetch PC select a counter
    logic             unused_f_pc_bits;
    assign unused_f_pc_bits = ^{bpu.f_pc[31:IDX_W+2], bpu.f_pc[1:0]};

    assign f_idx        = bpu.f_pc[IDX_W+1:2];
    assign d_idx        = bpu.d_pc[IDX_W+1:2];
    assign op           = branch_op_e'(bpu.d_branch_op);
    assign rs_neg       = bpu.d_rs[DATA_W-1];
    assign rs_zero      = (bpu.d_rs == '0);
    assign fall_through = bpu.d_pc + 32'd8;

    // Branch condition evaluation from forwarded operands
    always_comb begin
        cond      = 1'b0;
        is_branch = 1'b1;
        case (op)
            OP_BEQ:  cond = (bpu.d_rs == bpu.d_rt);
            OP_BNE:  cond = (bpu.d_rs != bpu.d_rt);
            OP_BGTZ: cond = ~rs_neg & ~rs_zero;
            OP_BLEZ: cond = rs_neg | rs_zero;
            OP_BLTZ: cond = rs_neg;
            OP_BGEZ: cond = ~rs_neg;
            default: is_branch = 1'b0;
        endcase
    end

    assign resolve = bpu.d_valid & ~bpu.d_stall & is_branch;
    assign taken   = resolve & cond;
    assign miss    = resolve & (taken != bpu.d_pred_taken);

    // Zero-latency outputs; lookup reads the pre-update counter (no bypass)
    always_comb begin
        bpu.f_pred_taken = bht[f_idx][1];
        bpu.br_taken     = taken;
        bpu.mispredict   = miss;
        bpu.redirect_pc  = '0;
        if (miss) begin
            bpu.redirect_pc = taken ? bpu.d_target : fall_through;
        end
    end

    assign bpu.stat_branches = stat_branches_q;
    assign bpu.stat_misses   = stat_misses_q;

    // BHT: reload on reset, otherwise train the resolving entry with saturation
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                bht[i] <= INIT_CNT;
            end
        end else if (resolve) begin
            if (taken) begin
                if (bht[d_idx] != 2'b11) begin
                    bht[d_idx] <= bht[d_idx] + 2'b01;
                end
            end else begin
                if (bht[d_idx] != 2'b00) begin
                    bht[d_idx] <= bht[d_idx] - 2'b01;
                end
            end
        end
    end

    // Saturating branch / mispredict counters
    always_ff @(posedge clk) begin
        if (reset) begin
            stat_branches_q <= '0;
            stat_misses_q   <= '0;
        end else if (resolve) begin
            if (stat_branches_q != '1) begin
                stat_branches_q <= stat_branches_q + 32'd1;
            end
            if (miss && (stat_misses_q != '1)) begin
                stat_misses_q <= stat_misses_q + 32'd1;
            end
        end
    end
endmodule

// File: tb/tb_branch_predict_unit.sv
// Self-checking bench for branch_predict_unit: a table of combinational
// resolve vectors checked through an expectation queue, followed by
// hand-written multi-cycle sequences for training, stall, reset and saturation.
module tb_branch_predict_unit;
    logic clk;
    logic reset;

    int n_tests;
    int n_fail;

    branch_predict_unit_if #(.DATA_W(32)) bif ();

    branch_predict_unit #(
        .DATA_W   (32),
        .IDX_W    (6),
        .INIT_CNT (2'b01)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bpu   (bif)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [2:0]  op;
        logic [31:0] rs;
        logic [31:0] rt;
        logic        pred;
        logic [31:0] pc;
        logic [31:0] tgt;
        logic        valid;
        logic        stall;
        logic        exp_taken;
        logic        exp_miss;
        logic [31:0] exp_redirect;
    } vec_t;

    typedef struct {
        logic        taken;
        logic        miss;
        logic [31:0] redirect;
    } exp_t;

    exp_t sb_q[$];

    function automatic vec_t mk(input logic [2:0] op, input logic [31:0] rs, input logic [31:0] rt,
                                input logic pred, input logic [31:0] pc, input logic [31:0] tgt,
                                input logic valid, input logic stall, input logic et,
                                input logic em, input logic [31:0] er);
        vec_t v;
        v.op = op; v.rs = rs; v.rt = rt; v.pred = pred; v.pc = pc; v.tgt = tgt;
        v.valid = valid; v.stall = stall;
        v.exp_taken = et; v.exp_miss = em; v.exp_redirect = er;
        return v;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic drive(input logic [2:0] op, input logic [31:0] rs, input logic [31:0] rt,
                         input logic pred, input logic [31:0] pc, input logic [31:0] tgt,
                         input logic valid, input logic stall);
        bif.d_branch_op  = op;
        bif.d_rs         = rs;
        bif.d_rt         = rt;
        bif.d_pred_taken = pred;
        bif.d_pc         = pc;
        bif.d_target     = tgt;
        bif.d_valid      = valid;
        bif.d_stall      = stall;
    endtask

    task automatic idle();
        drive(3'b000, 32'd0, 32'd0, 1'b0, 32'd0, 32'd0, 1'b0, 1'b0);
    endtask

    task automatic check_resolve(input string nm, input logic t, input logic m, input logic [31:0] r);
        chk({nm, ".br_taken"}, {31'd0, bif.br_taken}, {31'd0, t});
        chk({nm, ".mispredict"}, {31'd0, bif.mispredict}, {31'd0, m});
        chk({nm, ".redirect_pc"}, bif.redirect_pc, r);
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b1;
        idle();
        @(negedge clk);
        reset = 1'b0;
    endtask

    // Runaway guard
    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    vec_t vecs[15];

    initial begin
        exp_t e;
        n_tests = 0;
        n_fail  = 0;

        // Combinational resolve vectors: op, rs, rt, pred, pc, tgt, valid, stall -> taken, miss, redirect
        vecs[0]  = mk(3'b001, 32'd7, 32'd7, 1'b1, 32'h1000, 32'h2000, 1, 0, 1, 0, 32'h0);
        vecs[1]  = mk(3'b001, 32'd7, 32'd8, 1'b1, 32'h1000, 32'h2000, 1, 0, 0, 1, 32'h1008);
        vecs[2]  = mk(3'b010, 32'd7, 32'd8, 1'b0, 32'h1000, 32'h2000, 1, 0, 1, 1, 32'h2000);
        vecs[3]  = mk(3'b011, 32'hFFFF_FFFF, 32'd0, 1'b1, 32'h3020, 32'h3100, 1, 0, 0, 1, 32'h3028);
        vecs[4]  = mk(3'b110, 32'hFFFF_FFFF, 32'd0, 1'b0, 32'h3020, 32'h3100, 1, 0, 0, 0, 32'h0);
        vecs[5]  = mk(3'b101, 32'hFFFF_FFFF, 32'd0, 1'b0, 32'h3020, 32'h3100, 1, 0, 1, 1, 32'h3100);
        vecs[6]  = mk(3'b011, 32'd0, 32'd9, 1'b0, 32'h3020, 32'h3100, 1, 0, 0, 0, 32'h0);
        vecs[7]  = mk(3'b100, 32'd0, 32'd9, 1'b0, 32'h3020, 32'h0500, 1, 0, 1, 1, 32'h0500);
        vecs[8]  = mk(3'b100, 32'd1, 32'd0, 1'b1, 32'hFFFF_FFFC, 32'h0500, 1, 0, 0, 1, 32'h0000_0004);
        vecs[9]  = mk(3'b011, 32'h7FFF_FFFF, 32'd0, 1'b1, 32'h3020, 32'h0500, 1, 0, 1, 0, 32'h0);
        vecs[10] = mk(3'b000, 32'd3, 32'd3, 1'b0, 32'h3020, 32'h0500, 1, 0, 0, 0, 32'h0);
        vecs[11] = mk(3'b111, 32'd3, 32'd3, 1'b0, 32'h3020, 32'h0500, 1, 0, 0, 0, 32'h0);
        vecs[12] = mk(3'b001, 32'd3, 32'd3, 1'b0, 32'h3020, 32'h0500, 0, 0, 0, 0, 32'h0);
        vecs[13] = mk(3'b001, 32'd3, 32'd3, 1'b0, 32'h3020, 32'h0500, 1, 1, 0, 0, 32'h0);
        vecs[14] = mk(3'b110, 32'd0, 32'h1234_5678, 1'b1, 32'h3020, 32'h0500, 1, 0, 1, 0, 32'h0);

        // Reset state
        reset    = 1'b1;
        bif.f_pc = 32'h3000;
        idle();
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
        #1;
        chk("reset.f_pred_taken", {31'd0, bif.f_pred_taken}, 32'd0);
        chk("reset.stat_branches", bif.stat_branches, 32'd0);
        chk("reset.stat_misses", bif.stat_misses, 32'd0);

        // Table vectors via the expectation queue
        foreach (vecs[i]) begin
            @(negedge clk);
            drive(vecs[i].op, vecs[i].rs, vecs[i].rt, vecs[i].pred, vecs[i].pc, vecs[i].tgt,
                  vecs[i].valid, vecs[i].stall);
            e.taken    = vecs[i].exp_taken;
            e.miss     = vecs[i].exp_miss;
            e.redirect = vecs[i].exp_redirect;
            sb_q.push_back(e);
            #1;
            e = sb_q.pop_front();
            check_resolve($sformatf("vec%0d", i), e.taken, e.miss, e.redirect);
        end

        // Mispredicted taken beq trains entry 4; same-cycle lookup sees old value; aliasing PC shares it
        do_reset();
        bif.f_pc = 32'h3010;
        drive(3'b001, 32'd5, 32'd5, 1'b0, 32'h3010, 32'h3040, 1, 0);
        #1;
        check_resolve("beq_first", 1'b1, 1'b1, 32'h3040);
        chk("beq_first.same_cycle_pred", {31'd0, bif.f_pred_taken}, 32'd0);
        @(negedge clk);
        idle();
        #1;
        chk("beq_first.pred_after", {31'd0, bif.f_pred_taken}, 32'd1);
        chk("beq_first.stat_branches", bif.stat_branches, 32'd1);
        chk("beq_first.stat_misses", bif.stat_misses, 32'd1);
        bif.f_pc = 32'h3110;
        #1;
        chk("alias.pred", {31'd0, bif.f_pred_taken}, 32'd1);

        // Saturation: four taken then two not-taken at one PC
        do_reset();
        bif.f_pc = 32'h3100;
        for (int i = 0; i < 4; i++) begin
            drive(3'b001, 32'd1, 32'd1, 1'b1, 32'h3100, 32'h3400, 1, 0);
            @(negedge clk);
        end
        idle();
        #1;
        chk("sat4.pred", {31'd0, bif.f_pred_taken}, 32'd1);
        chk("sat4.stat_branches", bif.stat_branches, 32'd4);
        chk("sat4.stat_misses", bif.stat_misses, 32'd0);
        drive(3'b001, 32'd1, 32'd2, 1'b1, 32'h3100, 32'h3400, 1, 0);
        @(negedge clk);
        idle();
        #1;
        chk("sat_nt1.pred", {31'd0, bif.f_pred_taken}, 32'd1);
        chk("sat_nt1.stat_branches", bif.stat_branches, 32'd5);
        chk("sat_nt1.stat_misses", bif.stat_misses, 32'd1);
        drive(3'b001, 32'd1, 32'd2, 1'b1, 32'h3100, 32'h3400, 1, 0);
        @(negedge clk);
        idle();
        #1;
        chk("sat_nt2.pred", {31'd0, bif.f_pred_taken}, 32'd0);
        chk("sat_nt2.stat_branches", bif.stat_branches, 32'd6);

        // Stall holds a valid branch for 3 edges, then resolves exactly once
        do_reset();
        bif.f_pc = 32'h3200;
        drive(3'b001, 32'd9, 32'd9, 1'b0, 32'h3200, 32'h3300, 1, 1);
        #1;
        check_resolve("stall", 1'b0, 1'b0, 32'h0);
        repeat (3) @(negedge clk);
        #1;
        chk("stall.stat_branches", bif.stat_branches, 32'd0);
        chk("stall.pred", {31'd0, bif.f_pred_taken}, 32'd0);
        bif.d_stall = 1'b0;
        #1;
        check_resolve("unstall", 1'b1, 1'b1, 32'h3300);
        @(negedge clk);
        idle();
        #1;
        chk("unstall.stat_branches", bif.stat_branches, 32'd1);
        chk("unstall.stat_misses", bif.stat_misses, 32'd1);
        chk("unstall.pred", {31'd0, bif.f_pred_taken}, 32'd1);
        @(negedge clk);
        chk("unstall.once", bif.stat_branches, 32'd1);

        // Reserved op with valid instruction: no outputs, no update
        drive(3'b111, 32'd9, 32'd9, 1'b0, 32'h3200, 32'h3300, 1, 0);
        #1;
        check_resolve("op111", 1'b0, 1'b0, 32'h0);
        @(negedge clk);
        idle();
        #1;
        chk("op111.stat_branches", bif.stat_branches, 32'd1);
        chk("op111.pred", {31'd0, bif.f_pred_taken}, 32'd1);

        // Reset dominates a resolving branch on the same edge
        @(negedge clk);
        reset = 1'b1;
        drive(3'b001, 32'd9, 32'd9, 1'b0, 32'h3200, 32'h3300, 1, 0);
        #1;
        check_resolve("reset_resolve", 1'b1, 1'b1, 32'h3300);
        @(negedge clk);
        reset = 1'b0;
        idle();
        #1;
        chk("reset_resolve.stat_branches", bif.stat_branches, 32'd0);
        chk("reset_resolve.stat_misses", bif.stat_misses, 32'd0);
        chk("reset_resolve.pred", {31'd0, bif.f_pred_taken}, 32'd0);

        // Statistics saturate at all-ones
        @(negedge clk);
        force dut.stat_misses_q   = 32'hFFFF_FFFF;
        force dut.stat_branches_q = 32'hFFFF_FFFF;
        #1;
        release dut.stat_misses_q;
        release dut.stat_branches_q;
        drive(3'b001, 32'd9, 32'd9, 1'b0, 32'h3200, 32'h3300, 1, 0);
        @(negedge clk);
        idle();
        #1;
        chk("sat_stats.stat_misses", bif.stat_misses, 32'hFFFF_FFFF);
        chk("sat_stats.stat_branches", bif.stat_branches, 32'hFFFF_FFFF);

        if (sb_q.size() != 0) begin
            n_tests++;
            n_fail++;
            $display("FAIL scoreboard_drain: got %0d left expected 0", sb_q.size());
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
